seg7_scan_driver: RTL and testbench

Parametrised multi-digit, time-multiplexed seven-segment display driver. Holds a DIGITS-wide hex value in a tear-free shadow register and scans one digit at a time onto a shared active-low cathode bus with active-low anode enables. It adds three features: a programmable refresh rate, a dead-time between digits to prevent ghosting, and optional leading-zero suppression. It sits between the datapath/counter logic and the board display pins, and supersedes the single-digit hex decoder.

---
 rtl/seg7_scan_driver_if.sv | 23 ++
 rtl/seg7_scan_driver.sv | 169 ++++++++++++++++
 tb/tb_seg7_scan_driver.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_scan_driver_if.sv
// Bus between a display client and the seven-segment scan driver:
// hex value / decimal-point capture on the way in, scanned pins on the way out.
interface seg7_scan_driver_if #(
  parameter int DIGITS = 4
);
  logic [4*DIGITS-1:0] value;
  logic [DIGITS-1:0]   dp;
  logic                load;
  logic                blank_lz;
  logic [7:0]          Ca;
  logic [DIGITS-1:0]   An;
  logic                frame_tick;

  modport master (
    output value, dp, load, blank_lz,
    input  Ca, An, frame_tick
  );

  modport slave (
    input  value, dp, load, blank_lz,
    output Ca, An, frame_tick
  );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed seven-segment driver: tear-free shadowed hex value, per-slot
// dead time against ghosting, and optional leading-zero suppression.
module seg7_scan_driver #(
  parameter int DIGITS       = 4,
  parameter int REFRESH_DIV  = 100000,
  parameter int BLANK_CYCLES = 1000
) (
  input  logic                clk,
  input  logic                rst,
  seg7_scan_driver_if.slave   bus
);

  localparam int CNT_W = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [4*DIGITS-1:0] pend_v_q, pend_v_d;
  logic [DIGITS-1:0]   pend_dp_q, pend_dp_d;
  logic                pend_valid_q, pend_valid_d;
  logic [4*DIGITS-1:0] sh_v_q, sh_v_d;
  logic [DIGITS-1:0]   sh_dp_q, sh_dp_d;
  logic [7:0]          ca_q, ca_d;
  logic [DIGITS-1:0]   an_q, an_d;
  logic                frame_tick_q, frame_tick_d;

  logic slot_end;
  logic frame_end;
  logic in_blank;
  logic suppress;

  logic [3:0]        digit      [DIGITS];
  logic [6:0]        seg_all    [DIGITS];
  logic [DIGITS-1:0] digit_zero;
  logic [DIGITS-1:0] upper_zero;

  // Segment pattern g..a (active-low) for one hex nibble, dp bit dropped.
  function automatic logic [6:0] hex_seg(input logic [3:0] nib);
    logic [7:0] c;
    c = 8'hFF;
    case (nib)
      4'h0: c = 8'hC0;
      4'h1: c = 8'hF9;
      4'h2: c = 8'hA4;
      4'h3: c = 8'hB0;
      4'h4: c = 8'h99;
      4'h5: c = 8'h92;
      4'h6: c = 8'h82;
      4'h7: c = 8'hF8;
      4'h8: c = 8'h80;
      4'h9: c = 8'h98;
      4'hA: c = 8'h88;
      4'hB: c = 8'h83;
      4'hC: c = 8'hC6;
      4'hD: c = 8'hA1;
      4'hE: c = 8'h86;
      4'hF: c = 8'h8E;
      default: c = 8'hFF;
    endcase
    return c[6:0];
  endfunction

  // Scan position and shadow/pending capture.
  always_comb begin
    cnt_d        = cnt_q + CNT_W'(1);
    idx_d        = idx_q;
    pend_v_d     = pend_v_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;
    sh_v_d       = sh_v_q;
    sh_dp_d      = sh_dp_q;
    frame_tick_d = 1'b0;

    slot_end  = (cnt_q == CNT_LAST);
    frame_end = slot_end && (idx_q == IDX_LAST);

    if (slot_end) begin
      cnt_d = '0;
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
    end

    if (frame_end && bus.load) begin
      // A load landing on the boundary goes straight to the shadow.
      sh_v_d       = bus.value;
      sh_dp_d      = bus.dp;
      pend_valid_d = 1'b0;
      frame_tick_d = 1'b1;
    end else if (frame_end && pend_valid_q) begin
      sh_v_d       = pend_v_q;
      sh_dp_d      = pend_dp_q;
      pend_valid_d = 1'b0;
      frame_tick_d = 1'b1;
    end else if (bus.load) begin
      pend_v_d     = bus.value;
      pend_dp_d    = bus.dp;
      pend_valid_d = 1'b1;
    end
  end

  // Per-digit decode of the shadow value that will be live after this edge.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    assign digit[gi]      = sh_v_d[4*gi +: 4];
    assign seg_all[gi]    = hex_seg(digit[gi]);
    assign digit_zero[gi] = (digit[gi] == 4'h0);
  end

  // upper_zero[i]: digits DIGITS-1 down to i are all zero.
  always_comb begin
    logic acc;
    acc        = 1'b1;
    upper_zero = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      acc           = acc & digit_zero[i];
      upper_zero[i] = acc;
    end
  end

  if (BLANK_CYCLES == 0) begin : g_no_blank
    assign in_blank = 1'b0;
  end else begin : g_blank
    assign in_blank = (cnt_d < CNT_W'(BLANK_CYCLES));
  end

  assign suppress = bus.blank_lz && (idx_d != '0) && upper_zero[idx_d];

  always_comb begin
    ca_d = 8'hFF;
    an_d = '1;
    if (!in_blank) begin
      an_d     = ~(DIGITS'(1) << idx_d);
      ca_d[7]  = ~sh_dp_d[idx_d];
      ca_d[6:0] = suppress ? 7'h7F : seg_all[idx_d];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      pend_v_q     <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      sh_v_q       <= '0;
      sh_dp_q      <= '0;
      ca_q         <= 8'hFF;
      an_q         <= '1;
      frame_tick_q <= 1'b0;
    end else begin
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      pend_v_q     <= pend_v_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      sh_v_q       <= sh_v_d;
      sh_dp_q      <= sh_dp_d;
      ca_q         <= ca_d;
      an_q         <= an_d;
      frame_tick_q <= frame_tick_d;
    end
  end

  assign bus.Ca         = ca_q;
  assign bus.An         = an_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Randomised + directed bench for seg7_scan_driver; expected pins come from a
// frame-position model of the display and are checked by a decoupled monitor.
module tb_seg7_scan_driver;

  localparam int D     = 4;
  localparam int RD    = 8;
  localparam int B     = 2;
  localparam int FRAME = D * RD;

  typedef struct packed {
    logic [7:0]   ca;
    logic [D-1:0] an;
    logic         ft;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  seg7_scan_driver_if #(.DIGITS(D)) bus ();

  seg7_scan_driver #(
    .DIGITS(D), .REFRESH_DIV(RD), .BLANK_CYCLES(B)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  logic [7:0] hex_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                               8'h80, 8'h98, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   cyc      = 0;

  // Model state: position within the frame (0..FRAME-1), shadow and pending copies.
  int          pos = 0;
  logic [15:0] m_sh_v = '0, m_pend_v = '0;
  logic [3:0]  m_sh_dp = '0, m_pend_dp = '0;
  bit          m_pv = 0;
  bit          cur_lz = 0;

  task automatic cycle(input bit r, input bit ld, input logic [15:0] v,
                       input logic [3:0] d, input bit lz);
    exp_t e;
    int   slot, phase;
    bit   supp;
    logic [3:0] nib;
    @(negedge clk);
    rst          = r;
    bus.load     = ld;
    bus.value    = v;
    bus.dp       = d;
    bus.blank_lz = lz;
    if (!r) begin
      pos = 0; m_sh_v = '0; m_sh_dp = '0; m_pv = 0;
      e.ca = 8'hFF; e.an = '1; e.ft = 1'b0;
    end else begin
      e.ft = 1'b0;
      if (pos == FRAME - 1 && ld) begin
        m_sh_v = v; m_sh_dp = d; m_pv = 0; e.ft = 1'b1;
      end else if (pos == FRAME - 1 && m_pv) begin
        m_sh_v = m_pend_v; m_sh_dp = m_pend_dp; m_pv = 0; e.ft = 1'b1;
      end else if (ld) begin
        m_pend_v = v; m_pend_dp = d; m_pv = 1;
      end
      pos   = (pos + 1) % FRAME;
      slot  = pos / RD;
      phase = pos % RD;
      if (phase < B) begin
        e.ca = 8'hFF; e.an = '1;
      end else begin
        nib  = 4'((m_sh_v >> (4 * slot)) & 16'hF);
        supp = lz && slot > 0 && ((m_sh_v >> (4 * slot)) == 16'h0);
        e.an = ~(4'(1) << slot);
        e.ca = (supp ? 8'h7F : (hex_tab[nib] & 8'h7F)) | (m_sh_dp[slot] ? 8'h00 : 8'h80);
      end
    end
    exp_q.push_back(e);
  endtask

  task automatic idle();
    cycle(1'b1, 1'b0, 16'($urandom), 4'($urandom), cur_lz);
  endtask

  task automatic idle_n(input int n);
    for (int i = 0; i < n; i++) idle();
  endtask

  task automatic load(input logic [15:0] v, input logic [3:0] d);
    cycle(1'b1, 1'b1, v, d, cur_lz);
  endtask

  task automatic to_frame_end();
    while (pos != FRAME - 1) idle();
  endtask

  // Monitor: DUT pins are compared one time unit after each active edge.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_checks++;
      if (bus.Ca === e.ca) n_pass++;
      else $display("FAIL ca cyc=%0d got=%h exp=%h", cyc, bus.Ca, e.ca);
      n_checks++;
      if (bus.An === e.an) n_pass++;
      else $display("FAIL an cyc=%0d got=%b exp=%b", cyc, bus.An, e.an);
      n_checks++;
      if (bus.frame_tick === e.ft) n_pass++;
      else $display("FAIL frame_tick cyc=%0d got=%b exp=%b", cyc, bus.frame_tick, e.ft);
      $display("cyc=%0d Ca=%h An=%b ft=%b", cyc, bus.Ca, bus.An, bus.frame_tick);
    end
  end

  initial begin
    bus.value = '0; bus.dp = '0; bus.load = 1'b0; bus.blank_lz = 1'b0;

    // Reset hold, then one full frame of zeros.
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    idle_n(FRAME + 4);

    // Mid-frame load stays invisible until the boundary.
    load(16'h12AF, 4'b0100);
    idle_n(2 * FRAME);

    // Two loads in one frame: last wins, one tick.
    idle_n(5);
    load(16'h1111, 4'h0);
    idle_n(3);
    load(16'h2222, 4'h0);
    idle_n(2 * FRAME);

    // Load exactly on the boundary edge.
    to_frame_end();
    load(16'h0003, 4'h0);
    idle_n(2 * FRAME);

    // Leading-zero suppression.
    cur_lz = 1;
    load(16'h0040, 4'h0);
    idle_n(2 * FRAME);
    load(16'h0000, 4'b0100);
    idle_n(2 * FRAME);
    cur_lz = 0;

    // Reset mid-slot with a load pending.
    idle_n(3);
    load(16'h7777, 4'hF);
    idle_n(2);
    cycle(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    idle_n(2 * FRAME);

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) cur_lz = ~cur_lz;
      if ($urandom_range(0, 199) == 0)
        cycle(1'b0, 1'($urandom), 16'($urandom), 4'($urandom), cur_lz);
      else if ($urandom_range(0, 19) == 0)
        load(16'($urandom), 4'($urandom));
      else
        idle();
    end

    repeat (3) @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain got=%0d exp=0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
